// File: rtl/fft_stage_sched.sv
// 32-point radix-2 stage scheduler: buffers a serial frame, issues 16 butterflies to a shared unit,
// captures results in bit-reversed slots and unloads them serially. Optional status: FFT_SCHED_STATUS_EN.
module fft_stage_sched #(
  parameter int          IN_W   = 8,
  parameter int          OUT_W  = 8,
  parameter int unsigned BF_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_r,
  input  logic signed [IN_W-1:0]  in_i,
  output logic                    bf_valid,
  output logic signed [IN_W-1:0]  bf_x0_r,
  output logic signed [IN_W-1:0]  bf_x0_i,
  output logic signed [IN_W-1:0]  bf_x1_r,
  output logic signed [IN_W-1:0]  bf_x1_i,
  output logic                    bf_tw_en,
  input  logic signed [OUT_W-1:0] bf_p_r,
  input  logic signed [OUT_W-1:0] bf_p_i,
  input  logic signed [OUT_W-1:0] bf_n_r,
  input  logic signed [OUT_W-1:0] bf_n_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_r,
  output logic signed [OUT_W-1:0] out_i,
  output logic [4:0]              out_idx,
  output logic                    out_last,
`ifdef FFT_SCHED_STATUS_EN
  output logic [15:0]             frame_cnt,
  output logic                    err_push,
`endif
  output logic                    busy
);

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] UNLOAD = 2'd3;

  logic [1:0] state;
  logic       run;
  logic [4:0] in_cnt;
  logic [3:0] iss_cnt;
  logic [4:0] out_cnt;

  logic signed [IN_W-1:0]  ibuf_r [32];
  logic signed [IN_W-1:0]  ibuf_i [32];
  logic signed [OUT_W-1:0] obuf_r [32];
  logic signed [OUT_W-1:0] obuf_i [32];

  logic [BF_LAT-1:0] sr_v;
  logic [3:0]        sr_k [BF_LAT];

  logic       in_fire;
  logic       out_fire;
  logic       cap;
  logic [3:0] cap_k;
  logic [3:0] cap_rev;
  logic       unload;

  // run keeps in_ready low while reset is held even though state already reads LOAD
  assign in_ready  = run && (state == LOAD);
  assign in_fire   = in_valid && in_ready;
  assign busy      = (state != LOAD);
  assign unload    = (state == UNLOAD);

  assign bf_valid  = (state == ISSUE);
  assign bf_tw_en  = bf_valid && iss_cnt[0];
  assign bf_x0_r   = ibuf_r[{iss_cnt, 1'b0}];
  assign bf_x0_i   = ibuf_i[{iss_cnt, 1'b0}];
  assign bf_x1_r   = ibuf_r[{iss_cnt, 1'b1}];
  assign bf_x1_i   = ibuf_i[{iss_cnt, 1'b1}];

  assign cap       = sr_v[BF_LAT-1];
  assign cap_k     = sr_k[BF_LAT-1];
  assign cap_rev   = {cap_k[0], cap_k[1], cap_k[2], cap_k[3]};

  assign out_valid = unload;
  assign out_fire  = out_valid && out_ready;
  assign out_r     = unload ? obuf_r[out_cnt] : '0;
  assign out_i     = unload ? obuf_i[out_cnt] : '0;
  assign out_idx   = unload ? out_cnt : '0;
  assign out_last  = unload && (out_cnt == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      run     <= 1'b0;
      in_cnt  <= '0;
      iss_cnt <= '0;
      out_cnt <= '0;
      sr_v    <= '0;
    end else begin
      run     <= 1'b1;
      sr_v[0] <= bf_valid;
      for (int unsigned i = 1; i < BF_LAT; i++) begin
        sr_v[i] <= sr_v[i-1];
      end
      case (state)
        LOAD: begin
          if (in_fire) begin
            in_cnt <= in_cnt + 5'd1;
            if (in_cnt == 5'd31) state <= ISSUE;
          end
        end
        ISSUE: begin
          iss_cnt <= iss_cnt + 4'd1;
          if (iss_cnt == 4'd15) state <= DRAIN;
        end
        DRAIN: begin
          if (cap && (cap_k == 4'd15)) state <= UNLOAD;
        end
        UNLOAD: begin
          if (out_fire) begin
            out_cnt <= out_cnt + 5'd1;
            if (out_cnt == 5'd31) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Index tags and buffers carry no reset: only the valid bits decide whether they are used
  always_ff @(posedge clk) begin
    sr_k[0] <= iss_cnt;
    for (int unsigned i = 1; i < BF_LAT; i++) begin
      sr_k[i] <= sr_k[i-1];
    end
    if (in_fire) begin
      ibuf_r[in_cnt] <= in_r;
      ibuf_i[in_cnt] <= in_i;
    end
    if (cap) begin
      obuf_r[{1'b0, cap_rev}] <= bf_p_r;
      obuf_i[{1'b0, cap_rev}] <= bf_p_i;
      obuf_r[{1'b1, cap_rev}] <= bf_n_r;
      obuf_i[{1'b1, cap_rev}] <= bf_n_i;
    end
  end

`ifdef FFT_SCHED_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_push  <= 1'b0;
    end else begin
      err_push <= in_valid && busy;
      if (out_fire && out_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_stage_sched.sv
// Scoreboard bench for fft_stage_sched: three instances (BF_LAT 2, 1, 8) share stimulus,
// each with its own butterfly-unit model and expected-output queue.
module tb_fft_stage_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_r = '0;
  logic [7:0] in_i = '0;
  logic       out_ready = 1'b1;
  bit         stall_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] i;
    logic [4:0] idx;
    logic       last;
  } exp_t;

  exp_t       sb_q [3][$];
  logic [7:0] cur_r [32];
  logic [7:0] cur_i [32];
  logic [2:0] rdy_v;
  logic [2:0] busy_v;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Twiddle/butterfly reference: w0 = 1, w8 = -j, so x1*w8 = (x1_i, -x1_r)
  function automatic logic [31:0] bf_model(input logic [7:0] x0r, input logic [7:0] x0i,
                                           input logic [7:0] x1r, input logic [7:0] x1i,
                                           input logic tw);
    int ar, ai, br, bi;
    logic [7:0] pr, pi, nr, ni;
    ar = $signed(x0r);
    ai = $signed(x0i);
    if (tw) begin
      br = $signed(x1i);
      bi = -$signed(x1r);
    end else begin
      br = $signed(x1r);
      bi = $signed(x1i);
    end
    pr = 8'(ar + br);
    pi = 8'(ai + bi);
    nr = 8'(ar - br);
    ni = 8'(ai - bi);
    return {pr, pi, nr, ni};
  endfunction

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    logic        in_ready, bf_valid, bf_tw_en, out_valid, out_last, busy;
    logic [7:0]  x0r, x0i, x1r, x1i, pr, pi, nr, ni, o_r, o_i;
    logic [4:0]  o_idx;
    logic [31:0] pipe [LAT];
    int          ncyc = 0, t_busy = 0, kk = 0, rel = 0;
    logic        busy_d = 1'b0, ov_d = 1'b0;
    exp_t        e;
`ifdef FFT_SCHED_STATUS_EN
    logic [15:0] frame_cnt;
    logic        err_push;
    logic        err_seen = 1'b0;
`endif

    fft_stage_sched #(.IN_W(8), .OUT_W(8), .BF_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
      .bf_valid(bf_valid), .bf_x0_r(x0r), .bf_x0_i(x0i), .bf_x1_r(x1r), .bf_x1_i(x1i),
      .bf_tw_en(bf_tw_en),
      .bf_p_r(pr), .bf_p_i(pi), .bf_n_r(nr), .bf_n_i(ni),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(o_r), .out_i(o_i),
      .out_idx(o_idx), .out_last(out_last),
`ifdef FFT_SCHED_STATUS_EN
      .frame_cnt(frame_cnt), .err_push(err_push),
`endif
      .busy(busy)
    );

    assign rdy_v[g]  = in_ready;
    assign busy_v[g] = busy;
    assign {pr, pi, nr, ni} = pipe[LAT-1];

    always @(posedge clk) begin
      pipe[0] <= bf_model(x0r, x0i, x1r, x1i, bf_tw_en);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    always @(negedge clk) begin
      ncyc <= ncyc + 1;
      if (!rst_n) begin
        rel <= 0;
        check_eq($sformatf("rst_in_ready%0d", g), in_ready, 0);
        check_eq($sformatf("rst_bf_valid%0d", g), {bf_valid, bf_tw_en}, 0);
        check_eq($sformatf("rst_out%0d", g), {out_valid, out_last, busy}, 0);
        check_eq($sformatf("rst_data%0d", g), {o_r, o_i, o_idx}, 0);
      end else begin
        rel <= rel + 1;
        if (rel == 0) check_eq($sformatf("ready_after_rst%0d", g), in_ready, 1);
        if (!busy) kk <= 0;
        if (busy && !busy_d) t_busy <= ncyc;
        if (bf_valid) begin
          kk <= kk + 1;
          check_eq($sformatf("issue_cnt%0d", g), kk < 16, 1);
          if (kk < 16) begin
            check_eq($sformatf("x0%0d_k%0d", g, kk), {x0r, x0i}, {cur_r[2*kk], cur_i[2*kk]});
            check_eq($sformatf("x1%0d_k%0d", g, kk), {x1r, x1i}, {cur_r[2*kk+1], cur_i[2*kk+1]});
            check_eq($sformatf("tw%0d_k%0d", g, kk), bf_tw_en, kk & 1);
          end
        end
        if (out_valid && !ov_d) check_eq($sformatf("issue_to_unload%0d", g), ncyc - t_busy, 16 + LAT);
        if (out_valid) begin
          check_eq($sformatf("sb_nonempty%0d", g), sb_q[g].size() != 0, 1);
          if (sb_q[g].size() != 0) begin
            e = sb_q[g][0];
            check_eq($sformatf("out_idx%0d", g), o_idx, e.idx);
            check_eq($sformatf("out_r%0d_s%0d", g, e.idx), o_r, e.r);
            check_eq($sformatf("out_i%0d_s%0d", g, e.idx), o_i, e.i);
            check_eq($sformatf("out_last%0d_s%0d", g, e.idx), out_last, e.last);
            if (out_ready) void'(sb_q[g].pop_front());
          end
        end
`ifdef FFT_SCHED_STATUS_EN
        if (err_push) err_seen <= 1'b1;
`endif
      end
      busy_d <= busy;
      ov_d   <= out_valid;
    end
  end

  initial begin : ready_pattern
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        out_ready = pat[ph % 4];
        ph++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic wait_all_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (rdy_v != 3'b111 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("ready_wait", rdy_v, 3'b111);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy_v != 0 || sb_q[0].size() != 0 || sb_q[1].size() != 0 || sb_q[2].size() != 0)
           && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_wait", {busy_v, 8'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size())}, 0);
  endtask

  task automatic fill_frame(input int kind);
    for (int n = 0; n < 32; n++) begin
      case (kind)
        0:       begin cur_r[n] = 8'(n);                   cur_i[n] = 8'd0; end
        1:       begin cur_r[n] = (n == 0) ? 8'd1 : 8'd0;  cur_i[n] = 8'd0; end
        default: begin cur_r[n] = 8'($urandom_range(60) - 30);
                       cur_i[n] = 8'($urandom_range(60) - 30); end
      endcase
    end
  endtask

  task automatic drive_frame(input int kind);
    logic [31:0] bf;
    logic [3:0]  k;
    exp_t        e;
    wait_all_ready();
    fill_frame(kind);
    for (int n = 0; n < 32; n++) begin
      in_valid = 1'b1;
      in_r     = cur_r[n];
      in_i     = cur_i[n];
      @(posedge clk);
      #1;
    end
    for (int s = 0; s < 32; s++) begin
      k  = bitrev4(4'(s));
      bf = bf_model(cur_r[2*k], cur_i[2*k], cur_r[2*k+1], cur_i[2*k+1], k[0]);
      e.r    = (s < 16) ? bf[31:24] : bf[15:8];
      e.i    = (s < 16) ? bf[23:16] : bf[7:0];
      e.idx  = 5'(s);
      e.last = (s == 31);
      for (int j = 0; j < 3; j++) sb_q[j].push_back(e);
    end
    // Pushing while busy must be refused (and flagged when status is built in)
    in_r = 8'h55;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    drive_frame(0); wait_done();
    drive_frame(1); wait_done();
    stall_en = 1'b1;
    drive_frame(2); wait_done();
    stall_en = 1'b0;

`ifdef FFT_SCHED_STATUS_EN
    check_eq("frame_cnt0", g_i[0].frame_cnt, 3);
    check_eq("frame_cnt1", g_i[1].frame_cnt, 3);
    check_eq("frame_cnt2", g_i[2].frame_cnt, 3);
    check_eq("err_push_seen", {g_i[0].err_seen, g_i[1].err_seen, g_i[2].err_seen}, 3'b111);
`endif

    // Partial frame of 10 samples, then reset mid-frame; it must be discarded
    wait_all_ready();
    fill_frame(2);
    for (int n = 0; n < 10; n++) begin
      in_valid = 1'b1;
      in_r     = cur_r[n];
      in_i     = cur_i[n];
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    drive_frame(0); wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
